// File: rtl/sipp_pkg.sv
// Shared SIPP definitions: loader FSM states, default memory geometry and the
// bytes-per-word derivation used by the loader and the memory.
package sipp_pkg;

   localparam int unsigned ADDR_WIDTH_DEF = 8;
   localparam int unsigned DATA_WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      WRITE,
      DONE
   } state_e;

   function automatic int unsigned bpw(input int unsigned data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/sipp_mem_loader_if.sv
// Byte-stream, processor-side and memory-side port bundle of the SIPP loader.
// slave is the loader's view; master is the view of whatever surrounds it.
interface sipp_mem_loader_if
   import sipp_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);

   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;

   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic                  cpu_wr;
   logic                  cpu_rd;
   logic [DATA_WIDTH-1:0] cpu_w_data;
   logic [DATA_WIDTH-1:0] cpu_r_data;

   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_wr;
   logic                  mem_rd;
   logic [DATA_WIDTH-1:0] mem_w_data;
   logic [DATA_WIDTH-1:0] mem_r_data;

   modport slave (
      input  in_valid, in_data, cpu_addr, cpu_wr, cpu_rd, cpu_w_data, mem_r_data,
      output in_ready, cpu_r_data, mem_addr, mem_wr, mem_rd, mem_w_data
   );

   modport master (
      output in_valid, in_data, cpu_addr, cpu_wr, cpu_rd, cpu_w_data, mem_r_data,
      input  in_ready, cpu_r_data, mem_addr, mem_wr, mem_rd, mem_w_data
   );

endinterface

// File: rtl/sipp_word_assembler.sv
// Packs accepted bytes MSB-first into one memory word and counts them.
// full flags the handshake that supplies the last byte of the word.
module sipp_word_assembler
   import sipp_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  shift,
   input  logic                  clear,
   input  logic [7:0]            in_data,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  full
);

   localparam int unsigned BPW  = bpw(DATA_WIDTH);
   localparam int unsigned CntW = $clog2(BPW + 1);

   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [CntW-1:0]       cnt_q, cnt_d;

   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (clear) begin
         word_d = '0;
         cnt_d  = '0;
      end else if (shift) begin
         // Truncating the concatenation drops the oldest byte off the top.
         word_d = DATA_WIDTH'({word_q, in_data});
         cnt_d  = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

   assign word = word_q;
   assign full = shift && (cnt_q == CntW'(BPW - 1));

endmodule

// File: rtl/sipp_mem_loader.sv
// SIPP program loader: streams bytes into consecutive memory words from a base
// address, keeps a checksum, and owns the memory port while a load is running.
module sipp_mem_loader
   import sipp_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   len,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] checksum,
   sipp_mem_loader_if.slave      bus
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH:0]   len_q, len_d;
   logic [ADDR_WIDTH:0]   idx_q, idx_d;
   logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

   logic                  asm_shift;
   logic                  asm_clear;
   logic                  asm_full;
   logic [DATA_WIDTH-1:0] asm_word;

   assign asm_shift = (state_q == RECV) && bus.in_valid;

   sipp_word_assembler #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_word_assembler (
      .clk    (clk),
      .rst    (rst),
      .shift  (asm_shift),
      .clear  (asm_clear),
      .in_data(bus.in_data),
      .word   (asm_word),
      .full   (asm_full)
   );

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      len_d      = len_q;
      idx_d      = idx_q;
      checksum_d = checksum_q;
      asm_clear  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               base_d     = base_addr;
               len_d      = len;
               idx_d      = '0;
               checksum_d = '0;
               asm_clear  = 1'b1;
               state_d    = (len == '0) ? DONE : RECV;
            end
         end
         RECV: begin
            if (asm_full) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            checksum_d = checksum_q + asm_word;
            idx_d      = idx_q + 1'b1;
            asm_clear  = 1'b1;
            state_d    = (idx_q + 1'b1 == len_q) ? DONE : RECV;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         base_q     <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         checksum_q <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         checksum_q <= checksum_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign bus.in_ready = (state_q == RECV);
   assign checksum    = checksum_q;

   // Idle hands the memory to the processor; otherwise only WRITE touches it.
   always_comb begin
      bus.mem_addr   = bus.cpu_addr;
      bus.mem_wr     = bus.cpu_wr;
      bus.mem_rd     = bus.cpu_rd;
      bus.mem_w_data = bus.cpu_w_data;
      bus.cpu_r_data = bus.mem_r_data;
      if (state_q != IDLE) begin
         bus.mem_addr   = base_q + idx_q[ADDR_WIDTH-1:0];
         bus.mem_wr     = (state_q == WRITE);
         bus.mem_rd     = 1'b0;
         bus.mem_w_data = asm_word;
         bus.cpu_r_data = '0;
      end
   end

endmodule

// File: tb/tb_sipp_mem_loader.sv
// Directed bench for sipp_mem_loader with a behavioural 256x16 memory.
module tb_sipp_mem_loader;
   import sipp_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  base_addr;
   logic [8:0]  len;
   logic        busy;
   logic        done;
   logic [15:0] checksum;

   int n_cmp = 0;
   int n_err = 0;
   int wr_cnt = 0;

   always #5 clk = ~clk;

   sipp_mem_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

   sipp_mem_loader #(
      .ADDR_WIDTH(8),
      .DATA_WIDTH(16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .base_addr(base_addr),
      .len      (len),
      .busy     (busy),
      .done     (done),
      .checksum (checksum),
      .bus      (bus)
   );

   logic [15:0] mem [256];

   always_ff @(posedge clk) begin
      if (bus.mem_wr) begin
         mem[bus.mem_addr] <= bus.mem_w_data;
         wr_cnt            <= wr_cnt + 1;
      end
   end

   assign bus.mem_r_data = mem[bus.mem_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cpu_write(input logic [7:0] a, input logic [15:0] d);
      bus.cpu_addr   = a;
      bus.cpu_w_data = d;
      bus.cpu_wr     = 1'b1;
      tick();
      bus.cpu_wr     = 1'b0;
   endtask

   // Runs a load from the cycle start is raised until done is seen.
   task automatic run_load(input logic [7:0] b_base, input logic [8:0] b_len,
                           input logic [7:0] bytes [8], input bit gaps, input bit block,
                           output int cycles, output int hs_cnt);
      int bi;
      bit hs;
      bi        = 0;
      cycles    = 0;
      hs_cnt    = 0;
      base_addr = b_base;
      len       = b_len;
      start     = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = bytes[0];
      while (!done && cycles < 60) begin
         hs = bus.in_ready && bus.in_valid;
         tick();
         cycles++;
         if (hs) begin
            bi++;
            hs_cnt++;
         end
         bus.in_data = bytes[bi[2:0]];
         if (gaps) bus.in_valid = ~bus.in_valid;
         if (block) begin
            start          = 1'b1;
            base_addr      = 8'h30;
            len            = 9'd1;
            bus.cpu_addr   = 8'h20;
            bus.cpu_w_data = 16'hDEAD;
            bus.cpu_wr     = 1'b1;
            bus.cpu_rd     = 1'b1;
            #1;
            if (bus.in_ready) begin
               chk("blk_cpu_r_data", 32'(bus.cpu_r_data), 32'h0);
               chk("blk_mem_rd", 32'(bus.mem_rd), 32'h0);
               chk("blk_mem_wr", 32'(bus.mem_wr), 32'h0);
            end
         end else begin
            start = 1'b0;
         end
      end
      start        = 1'b0;
      bus.cpu_wr   = 1'b0;
      bus.cpu_rd   = 1'b0;
      bus.in_valid = 1'b0;
      chk("done_seen", 32'(done), 32'h1);
   endtask

   initial begin
      logic [7:0] bv [8];
      int cyc;
      int hsn;
      int wr0;

      rst            = 1'b1;
      start          = 1'b0;
      base_addr      = '0;
      len            = '0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.cpu_addr   = '0;
      bus.cpu_wr     = 1'b0;
      bus.cpu_rd     = 1'b0;
      bus.cpu_w_data = '0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state and idle passthrough
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
      chk("rst_checksum", 32'(checksum), 32'h0);
      bus.cpu_addr   = 8'h10;
      bus.cpu_w_data = 16'hBEEF;
      bus.cpu_wr     = 1'b1;
      #1;
      chk("pass_mem_wr", 32'(bus.mem_wr), 32'h1);
      chk("pass_mem_addr", 32'(bus.mem_addr), 32'h10);
      tick();
      bus.cpu_wr = 1'b0;
      bus.cpu_rd = 1'b1;
      #1;
      chk("pass_mem_rd", 32'(bus.mem_rd), 32'h1);
      chk("pass_r_data", 32'(bus.cpu_r_data), 32'hBEEF);
      bus.cpu_rd = 1'b0;
      cpu_write(8'h20, 16'h1111);
      cpu_write(8'h41, 16'h5A5A);

      // Basic load, valid held high
      bv  = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h00, 8'h00};
      wr0 = wr_cnt;
      run_load(8'h00, 9'd3, bv, 1'b0, 1'b0, cyc, hsn);
      chk("basic_cycles", 32'(cyc), 32'd10);
      chk("basic_busy_in_done", 32'(busy), 32'h1);
      chk("basic_checksum", 32'(checksum), 32'h0368);
      tick();
      chk("basic_done_pulse", 32'(done), 32'h0);
      chk("basic_busy_fall", 32'(busy), 32'h0);
      chk("basic_writes", 32'(wr_cnt - wr0), 32'd3);
      chk("basic_mem0", 32'(mem[0]), 32'h1234);
      chk("basic_mem1", 32'(mem[1]), 32'h5678);
      chk("basic_mem2", 32'(mem[2]), 32'h9ABC);
      chk("basic_cs_hold", 32'(checksum), 32'h0368);
      bus.cpu_addr = 8'h02;
      bus.cpu_rd   = 1'b1;
      #1;
      chk("basic_rd_back", 32'(bus.cpu_r_data), 32'h9ABC);
      bus.cpu_rd = 1'b0;

      // Address wrap with in_valid gaps
      bv  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
      wr0 = wr_cnt;
      run_load(8'hFF, 9'd2, bv, 1'b1, 1'b0, cyc, hsn);
      chk("wrap_handshakes", 32'(hsn), 32'd4);
      chk("wrap_checksum", 32'(checksum), 32'h4466);
      tick();
      chk("wrap_writes", 32'(wr_cnt - wr0), 32'd2);
      chk("wrap_memFF", 32'(mem[8'hFF]), 32'h1122);
      chk("wrap_mem00", 32'(mem[0]), 32'h3344);
      chk("wrap_mem01", 32'(mem[1]), 32'h5678);

      // Processor blocked and start ignored during a load
      bv  = '{8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      wr0 = wr_cnt;
      run_load(8'h80, 9'd1, bv, 1'b0, 1'b1, cyc, hsn);
      chk("blk_cycles", 32'(cyc), 32'd4);
      chk("blk_checksum", 32'(checksum), 32'hABCD);
      tick();
      chk("blk_busy_after", 32'(busy), 32'h0);
      chk("blk_writes", 32'(wr_cnt - wr0), 32'd1);
      chk("blk_mem80", 32'(mem[8'h80]), 32'hABCD);
      chk("blk_mem20", 32'(mem[8'h20]), 32'h1111);

      // Zero-length load
      wr0 = wr_cnt;
      run_load(8'h50, 9'd0, bv, 1'b0, 1'b0, cyc, hsn);
      chk("len0_cycles", 32'(cyc), 32'd1);
      chk("len0_checksum", 32'(checksum), 32'h0);
      tick();
      chk("len0_writes", 32'(wr_cnt - wr0), 32'd0);
      chk("len0_busy", 32'(busy), 32'h0);

      // Reset after the first word of a four-word load
      base_addr    = 8'h40;
      len          = 9'd4;
      start        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hC0;
      tick();
      start = 1'b0;
      chk("mid_in_ready", 32'(bus.in_ready), 32'h1);
      tick();
      bus.in_data = 8'hDE;
      tick();
      #1;
      chk("mid_write_wr", 32'(bus.mem_wr), 32'h1);
      chk("mid_write_addr", 32'(bus.mem_addr), 32'h40);
      chk("mid_write_data", 32'(bus.mem_w_data), 32'hC0DE);
      bus.in_data = 8'h77;
      tick();
      chk("mid_cs_before", 32'(checksum), 32'hC0DE);
      rst = 1'b1;
      tick();
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
      chk("mid_rst_checksum", 32'(checksum), 32'h0);
      chk("mid_rst_done", 32'(done), 32'h0);
      chk("mid_mem40", 32'(mem[8'h40]), 32'hC0DE);
      chk("mid_mem41", 32'(mem[8'h41]), 32'h5A5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
